// File: rtl/note_stream_rx.sv
// rtl/note_stream_rx.sv - note stream UART receiver with byte decode and note FIFO
//
// Receives 8N1 frames (8E1 when NOTE_RX_PARITY_EN is defined), decodes each
// byte into a 4-bit note, an end-of-song marker or a code error, and buffers
// notes in a first-word-fall-through FIFO.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   clr        synchronous flush of FIFO and overflow
//   rd_en      pop FIFO head (ignored when empty)
//   note_out   FIFO head note, 0 when empty
//   note_valid FIFO non-empty
//   fill       FIFO occupancy
//   song_end   one-cycle pulse on byte 0xFF
//   frame_err  one-cycle pulse on bad stop bit (or bad parity)
//   code_err   one-cycle pulse on an undefined byte
//   overflow   sticky, a note was dropped on a full FIFO
module note_stream_rx #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx,
   input  logic                          clr,
   input  logic                          rd_en,
   output logic [3:0]                    note_out,
   output logic                          note_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fill,
   output logic                          song_end,
   output logic                          frame_err,
   output logic                          code_err,
   output logic                          overflow
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
`ifdef NOTE_RX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t          state, state_nx;
   logic            rx_m, rx_s;
   logic [TW-1:0]   timer;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            tick;
   logic            load_half, load_full, shift_en, byte_ok, bad_frame, par_ok;
   logic            push_q;
   logic [3:0]      push_note;

   // Two-flop synchronizer; resets to the idle level so no false start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   assign tick = (timer == '0);

`ifdef NOTE_RX_PARITY_EN
   logic par_bit, par_en;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        par_bit <= 1'b0;
      else if (par_en) par_bit <= rx_s;
   end
   assign par_ok = ~^{shreg, par_bit};
`else
   assign par_ok = 1'b1;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (!rx_s) state_nx = S_START;
         S_START:  if (tick) state_nx = rx_s ? S_IDLE : S_DATA;
`ifdef NOTE_RX_PARITY_EN
         S_DATA:   if (tick && bit_cnt == 3'd7) state_nx = S_PARITY;
         S_PARITY: if (tick) state_nx = S_STOP;
`else
         S_DATA:   if (tick && bit_cnt == 3'd7) state_nx = S_STOP;
`endif
         S_STOP:   if (tick) state_nx = rx_s ? S_IDLE : S_BREAK;
         S_BREAK:  if (rx_s) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Output / datapath control
   always_comb begin
      load_half = 1'b0;
      load_full = 1'b0;
      shift_en  = 1'b0;
      byte_ok   = 1'b0;
      bad_frame = 1'b0;
`ifdef NOTE_RX_PARITY_EN
      par_en    = 1'b0;
`endif
      case (state)
         S_IDLE:  load_half = !rx_s;
         S_START: load_full = tick && !rx_s;
         S_DATA: begin
            shift_en  = tick;
            load_full = tick;
         end
`ifdef NOTE_RX_PARITY_EN
         S_PARITY: begin
            par_en    = tick;
            load_full = tick;
         end
`endif
         S_STOP: begin
            byte_ok   = tick && rx_s && par_ok;
            bad_frame = tick && !(rx_s && par_ok);
         end
         default: ;
      endcase
   end

   // Bit timer, bit counter and shift register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer   <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         if (load_half)      timer <= HALF_M1;
         else if (load_full) timer <= FULL_M1;
         else if (!tick)     timer <= timer - TW'(1);
         if (state != S_DATA) bit_cnt <= '0;
         else if (shift_en)   bit_cnt <= bit_cnt + 3'd1;
         if (shift_en) shreg <= {rx_s, shreg[7:1]};
      end
   end

   // Decode stage: pulses and push request are registered on the stop sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         song_end  <= 1'b0;
         code_err  <= 1'b0;
         frame_err <= 1'b0;
         push_q    <= 1'b0;
         push_note <= '0;
      end else begin
         song_end  <= byte_ok && (shreg == 8'hFF);
         code_err  <= byte_ok && (shreg != 8'hFF) && (shreg[7:4] != 4'h0);
         frame_err <= bad_frame;
         push_q    <= byte_ok && (shreg[7:4] == 4'h0);
         push_note <= shreg[3:0];
      end
   end

   // Note FIFO
   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, do_pop, do_push;

   assign full    = (count == DEPTH);
   assign do_pop  = rd_en && (count != '0) && !clr;
   // A full FIFO still accepts a push when a pop frees a slot on the same edge.
   assign do_push = push_q && !clr && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_note;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
         else if (do_pop && !do_push) count <= count - (AW + 1)'(1);
         if (push_q && !do_push) overflow <= 1'b1;
      end
   end

   assign note_out   = (count != '0) ? mem[rd_ptr] : 4'h0;
   assign note_valid = (count != '0);
   assign fill       = count;

endmodule

// File: tb/tb_note_stream_rx.sv
// tb/tb_note_stream_rx.sv - randomized self-checking bench for note_stream_rx
module tb_note_stream_rx;

   localparam int C = 16;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst, rx, clr, rd_en;
   logic [3:0] note_out;
   logic       note_valid, song_end, frame_err, code_err, overflow;
   logic [$clog2(D):0] fill;

   note_stream_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .rx(rx), .clr(clr), .rd_en(rd_en),
      .note_out(note_out), .note_valid(note_valid), .fill(fill),
      .song_end(song_end), .frame_err(frame_err), .code_err(code_err),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: queue of buffered notes plus expected event counts.
   int q[$];
   bit m_ovf = 1'b0;
   int exp_song = 0, exp_code = 0, exp_frame = 0;
   int got_song = 0, got_code = 0, got_frame = 0;
   bit quiet = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Count every cycle each pulse output is high: a stuck pulse over-counts.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         got_song  += int'(song_end);
         got_code  += int'(code_err);
         got_frame += int'(frame_err);
      end
   end

   // Per-cycle comparison against the model whenever the line is quiet.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         chk("valid_vs_fill", int'(note_valid), int'(fill != 0));
         if (quiet) begin
            chk("fill", int'(fill), q.size());
            chk("head", int'(note_out), (q.size() != 0) ? q[0] : 0);
            chk("overflow", int'(overflow), int'(m_ovf));
         end
      end
   end

   task automatic bit_out(input logic v);
      rx = v;
      repeat (C) @(posedge clk);
      #1;
   endtask

   // kind: 0 good frame, 1 stop bit held low for two bit times, 2 flipped parity
   task automatic send_frame(input logic [7:0] b, input int kind);
      quiet = 1'b0;
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef NOTE_RX_PARITY_EN
      bit_out((^b) ^ (kind == 2));
`endif
      if (kind == 1) begin
         bit_out(1'b0);
         bit_out(1'b0);
      end
      bit_out(1'b1);
      if (kind != 0)        exp_frame++;
      else if (b < 8'h10) begin
         if (q.size() < D) q.push_back(int'(b));
         else              m_ovf = 1'b1;
      end
      else if (b == 8'hFF)  exp_song++;
      else                  exp_code++;
   endtask

   task automatic settle(input int n);
      quiet = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      chk("song_end_count", got_song, exp_song);
      chk("code_err_count", got_code, exp_code);
      chk("frame_err_count", got_frame, exp_frame);
   endtask

   task automatic pop();
      quiet = 1'b0;
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
      settle(1);
   endtask

   task automatic do_clr();
      quiet = 1'b0;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      settle(1);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, np, kind;
      logic [7:0] b;
      rst = 1'b0; rx = 1'b1; clr = 1'b0; rd_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_fill", int'(fill), 0);
      chk("rst_valid", int'(note_valid), 0);
      chk("rst_note", int'(note_out), 0);
      chk("rst_song", int'(song_end), 0);
      chk("rst_frame", int'(frame_err), 0);
      chk("rst_code", int'(code_err), 0);
      chk("rst_ovf", int'(overflow), 0);
      rst = 1'b1;
      settle(C);

      // Two notes, then a pop
      send_frame(8'h03, 0);
      send_frame(8'h0A, 0);
      settle(2);
      chk("lit_fill2", int'(fill), 2);
      chk("lit_head3", int'(note_out), 3);
      pop();
      chk("lit_headA", int'(note_out), 10);
      chk("lit_fill1", int'(fill), 1);
      pop();

      // End-of-song and code error
      send_frame(8'hFF, 0);
      send_frame(8'h42, 0);
      settle(2);
      chk("lit_song1", got_song, 1);
      chk("lit_code1", got_code, 1);
      chk("lit_fill0", int'(fill), 0);

      // Bad stop bit, then recovery
      send_frame(8'h05, 1);
      send_frame(8'h06, 0);
      settle(2);
      chk("lit_frame1", got_frame, 1);
      chk("lit_head6", int'(note_out), 6);
      pop();

      // Overflow and flush
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 0);
      settle(2);
      chk("lit_fill4", int'(fill), 4);
      chk("lit_ovf1", int'(overflow), 1);
      chk("lit_head1", int'(note_out), 1);
      do_clr();
      chk("lit_clr_fill", int'(fill), 0);
      chk("lit_clr_ovf", int'(overflow), 0);
      chk("lit_clr_valid", int'(note_valid), 0);

      // Short glitch on the line
      quiet = 1'b0;
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx = 1'b1;
      settle(2 * C);
      send_frame(8'h09, 0);
      settle(2);
      chk("lit_glitch_head", int'(note_out), 9);
      pop();

      // Reset in the middle of frame 0x07
      send_frame(8'h0C, 0);
      settle(2);
      quiet = 1'b0;
      bit_out(1'b0);
      bit_out(1'b1);
      bit_out(1'b1);
      bit_out(1'b1);
      rst = 1'b0;
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      m_ovf = 1'b0;
      settle(C);
      send_frame(8'h01, 0);
      settle(2);
      chk("lit_rst_fill", int'(fill), 1);
      chk("lit_rst_head", int'(note_out), 1);
      pop();

`ifdef NOTE_RX_PARITY_EN
      send_frame(8'h03, 2);
      settle(2);
      chk("lit_par_fill", int'(fill), 0);
`endif

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 99);
         kind = 0;
         if (r < 60)      b = 8'($urandom_range(0, 15));
         else if (r < 70) b = 8'hFF;
         else if (r < 88) b = 8'($urandom_range(16, 254));
         else begin
            b = 8'($urandom_range(0, 255));
`ifdef NOTE_RX_PARITY_EN
            kind = ($urandom_range(0, 1) == 0) ? 1 : 2;
`else
            kind = 1;
`endif
         end
         send_frame(b, kind);
         if ($urandom_range(0, 3) != 0) begin
            settle($urandom_range(1, 3));
            np = $urandom_range(0, 2);
            for (int k = 0; k < np; k++) pop();
            if ($urandom_range(0, 15) == 0) do_clr();
         end
      end
      settle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/note_stream_rx.md
# note_stream_rx

Serial receiver for the note stream that the music ROM transmitters emit on `notes_left` / `notes_right`. The block deserialises 8N1 UART frames, decodes each byte into a 4-bit note code or an end-of-song marker, and buffers notes in a first-word-fall-through FIFO for a downstream tile/rail renderer. One instance sits per hand, on the receiving board or in loopback on the same FPGA.

## Interface
- `CLKS_PER_BIT`, 10417, clock cycles per UART bit (100 MHz / 9600 baud); must be ≥ 4.
- `FIFO_DEPTH`, 16, note FIFO entries; power of two, ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `clr`  in  1  synchronous flush: empties the FIFO and clears `overflow`.
- `rd_en`  in  1  pop the FIFO head; ignored when `note_valid`=0.
- `note_out`  out  4  FIFO head note code; 0 when empty.
- `note_valid`  out  1  FIFO non-empty.
- `fill`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `song_end`  out  1  one-cycle pulse on receipt of byte 0xFF.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit (or bad parity, see Configuration).
- `code_err`  out  1  one-cycle pulse on a byte that is neither 0x00–0x0F nor 0xFF.
- `overflow`  out  1  sticky; set when a note is dropped because the FIFO is full.

## Operation
- `rx` passes through a 2-FF synchronizer; every reference to `rx` below means the synchronized value.
- Receiver FSM:
  - IDLE: on `rx`=0, go to START and load the bit timer with CLKS_PER_BIT/2.
  - START: at timer expiry, if `rx`=1 the start was a glitch and the FSM returns to IDLE; otherwise it goes to DATA with the timer reloaded to CLKS_PER_BIT.
  - DATA: samples 8 bits LSB first, one at each timer expiry, then goes to STOP (or PARITY).
  - STOP: samples once at timer expiry.
    - `rx`=1: the byte is complete and the FSM goes to IDLE.
    - `rx`=0: the FSM pulses `frame_err`, drops the byte, and goes to BREAK.
  - BREAK: waits for `rx`=1, then goes to IDLE.
- Byte decode on a completed byte:
  - 0x00–0x0F: push low nibble.
  - 0xFF: pulse `song_end`; nothing is pushed.
  - Any other value: pulse `code_err`; nothing is pushed.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - `note_out` is combinational from the head entry, forced to 0 when empty.
  - Push when full: the note is dropped and `overflow` is set. This does not apply when `rd_en` is also asserted in that cycle. Then both the push and the pop happen and the count is unchanged.
  - Push and pop in the same cycle when not full: the count is unchanged.
  - Pop when empty: no effect.
- `clr` has priority over push and pop in the same cycle: the FIFO empties, `overflow`=0, and any push that cycle is lost. `clr` does not disturb a frame in progress.
- Reset mid-frame: the FSM returns to IDLE immediately, the FIFO empties, and the partial byte is discarded.

## Timing
- Reset values: `note_out`=0, `note_valid`=0, `fill`=0, `song_end`=0, `frame_err`=0, `code_err`=0, `overflow`=0; FSM in IDLE.
- The stop-bit sample lands CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the synchronized falling edge, or +10·CLKS_PER_BIT with parity.
- The decode result is registered in the cycle after the stop sample. In that same cycle `song_end`, `code_err` or `frame_err` pulses high.
- For a note byte, the FIFO write occurs on that same edge. `note_valid` and `fill` update on the next cycle.
- Pop: on the cycle after `rd_en`, `fill` decrements and `note_out` shows the next entry.
- Back-to-back frames are supported: a start bit arriving immediately after the stop sample is detected.

## Configuration
- `NOTE_RX_PARITY_EN`:
  - Defined: the frame is 8E1. After DATA the FSM enters PARITY and samples one extra bit. An even-parity mismatch pulses `frame_err` in the decode cycle and drops the byte, even if the stop bit is good.
  - Undefined: the frame is 8N1 and no PARITY state exists.

## Test plan
- Reset, then frames 0x03, 0x0A sent at CLKS_PER_BIT=16 -> `fill`=2 and `note_out`=3; after `rd_en` for 1 cycle, `note_out`=0xA and `fill`=1.
- Byte 0xFF -> one-cycle `song_end` pulse and `fill` unchanged; byte 0x42 -> one-cycle `code_err` pulse and nothing pushed.
- Frame 0x05 with stop bit held 0 for 2 bit times -> `frame_err` pulses once and nothing is pushed; the next good frame 0x06 is received normally.
- FIFO_DEPTH=4: send 5 notes with no reads -> `fill`=4 and `overflow`=1, and `note_out` is the first note. Assert `clr` -> `fill`=0, `overflow`=0 and `note_valid`=0.
- A 3-cycle low glitch on `rx` (< CLKS_PER_BIT/2) -> no push and no error pulses, and the FSM is back in IDLE.
- Assert `rst` in the middle of the DATA bits of frame 0x07, then send 0x01 -> only 0x01 appears in the FIFO. Under `NOTE_RX_PARITY_EN`, a frame with flipped parity -> `frame_err` pulses and nothing is pushed.
